// File: rtl/nd_zigzag_agu.sv
// MVU address generator: NDIM-deep shared loop nest with a bit-serial zig-zag pass between levels 0 and 1.
// Drives lockstep data/weight addresses with valid/ready, accumulator shift/done flags and an end-of-job pulse.
module nd_zigzag_agu #(
  parameter int NDIM     = 4,
  parameter int BPREC    = 6,
  parameter int BDBANKA  = 15,
  parameter int BWBANKA  = 9,
  parameter int BWLENGTH = 8
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        start,
  input  logic                        out_ready,
  input  logic [BPREC-1:0]            iprecision,
  input  logic [BPREC-1:0]            wprecision,
  input  logic [NDIM*BWLENGTH-1:0]    length,
  input  logic [NDIM*BDBANKA-1:0]     istride,
  input  logic [NDIM*BWBANKA-1:0]     wstride,
  input  logic [BDBANKA-1:0]          ibaseaddr,
  input  logic [BWBANKA-1:0]          wbaseaddr,
  output logic                        out_valid,
  output logic [BDBANKA-1:0]          iaddr,
  output logic [BWBANKA-1:0]          waddr,
  output logic                        imsb,
  output logic                        wmsb,
  output logic                        sh,
  output logic                        acc_done,
  output logic                        busy,
  output logic                        done
);
  localparam int SW = BPREC + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state;

  logic [BPREC-1:0]    ip_q, wp_q, ip_c, wp_c;
  logic [BWLENGTH-1:0] len_q [NDIM];
  logic [BWLENGTH-1:0] len_c [NDIM];
  logic [BDBANKA-1:0]  istr_q [NDIM];
  logic [BDBANKA-1:0]  istr_c [NDIM];
  logic [BWBANKA-1:0]  wstr_q [NDIM];
  logic [BWBANKA-1:0]  wstr_c [NDIM];
  logic [BDBANKA-1:0]  ibase_q, ibase_c;
  logic [BWBANKA-1:0]  wbase_q, wbase_c;

  logic [BWLENGTH-1:0] idx_q [NDIM];
  logic [BWLENGTH-1:0] idx_n [NDIM];
  logic [BDBANKA-1:0]  isum_q [NDIM];
  logic [BDBANKA-1:0]  isum_n [NDIM];
  logic [BWBANKA-1:0]  wsum_q [NDIM];
  logic [BWBANKA-1:0]  wsum_n [NDIM];
  logic [SW-1:0]       s_q, s_n, s_last, ipx, wpx, diag_hi;
  logic [BPREC-1:0]    offw_q, offw_n, offd_q, offd_n;

  logic [BDBANKA-1:0]  iaddr_n;
  logic [BWBANKA-1:0]  waddr_n;
  logic                sh_n, acc_n, last_n, last_q;

  function automatic logic [SW-1:0] diag_lo(input logic [SW-1:0] s, input logic [SW-1:0] ipe);
    return (s >= ipe) ? s - ipe + 1'b1 : '0;
  endfunction

  // On the latch edge the live inputs feed the first address; afterwards the latched copy does.
  always_comb begin
    if (state == IDLE) begin
      ip_c    = (iprecision == '0) ? BPREC'(1) : iprecision;
      wp_c    = (wprecision == '0) ? BPREC'(1) : wprecision;
      ibase_c = ibaseaddr;
      wbase_c = wbaseaddr;
      for (int k = 0; k < NDIM; k++) begin
        len_c[k]  = (length[k*BWLENGTH +: BWLENGTH] == '0) ? BWLENGTH'(1)
                                                         : length[k*BWLENGTH +: BWLENGTH];
        istr_c[k] = istride[k*BDBANKA +: BDBANKA];
        wstr_c[k] = wstride[k*BWBANKA +: BWBANKA];
      end
    end else begin
      ip_c    = ip_q;
      wp_c    = wp_q;
      ibase_c = ibase_q;
      wbase_c = wbase_q;
      for (int k = 0; k < NDIM; k++) begin
        len_c[k]  = len_q[k];
        istr_c[k] = istr_q[k];
        wstr_c[k] = wstr_q[k];
      end
    end
    ipx     = {1'b0, ip_c};
    wpx     = {1'b0, wp_c};
    s_last  = ipx + wpx - SW'(2);
    diag_hi = (s_q < wpx) ? s_q : wpx - 1'b1;
  end

  always_comb begin
    logic          carry;
    logic [SW-1:0] s1;
    for (int k = 0; k < NDIM; k++) begin
      idx_n[k]  = idx_q[k];
      isum_n[k] = isum_q[k];
      wsum_n[k] = wsum_q[k];
    end
    s_n    = s_q;
    offw_n = offw_q;
    offd_n = offd_q;
    carry  = 1'b0;
    s1     = s_q + 1'b1;
    if (idx_q[0] != len_c[0] - 1'b1) begin
      idx_n[0]  = idx_q[0] + 1'b1;
      isum_n[0] = isum_q[0] + istr_c[0];
      wsum_n[0] = wsum_q[0] + wstr_c[0];
    end else begin
      idx_n[0]  = '0;
      isum_n[0] = '0;
      wsum_n[0] = '0;
      if ({1'b0, offw_q} != diag_hi) begin
        offw_n = offw_q + 1'b1;
        offd_n = offd_q - 1'b1;
      end else if (s_q != s_last) begin
        s_n    = s1;
        offw_n = BPREC'(diag_lo(s1, ipx));
        offd_n = BPREC'(s1 - diag_lo(s1, ipx));
      end else begin
        s_n    = '0;
        offw_n = '0;
        offd_n = '0;
        carry  = 1'b1;
      end
    end
    for (int k = 1; k < NDIM; k++) begin
      if (carry) begin
        if (idx_q[k] != len_c[k] - 1'b1) begin
          idx_n[k]  = idx_q[k] + 1'b1;
          isum_n[k] = isum_q[k] + istr_c[k];
          wsum_n[k] = wsum_q[k] + wstr_c[k];
          carry     = 1'b0;
        end else begin
          idx_n[k]  = '0;
          isum_n[k] = '0;
          wsum_n[k] = '0;
        end
      end
    end
    if (state == IDLE) begin
      for (int k = 0; k < NDIM; k++) begin
        idx_n[k]  = '0;
        isum_n[k] = '0;
        wsum_n[k] = '0;
      end
      s_n    = '0;
      offw_n = '0;
      offd_n = '0;
    end
  end

  always_comb begin
    iaddr_n = ibase_c + BDBANKA'(offd_n);
    waddr_n = wbase_c + BWBANKA'(offw_n);
    last_n  = 1'b1;
    for (int k = 0; k < NDIM; k++) begin
      iaddr_n = iaddr_n + isum_n[k];
      waddr_n = waddr_n + wsum_n[k];
    end
    for (int k = 1; k < NDIM; k++)
      if (idx_n[k] != len_c[k] - 1'b1) last_n = 1'b0;
    sh_n   = (idx_n[0] == '0) && ({1'b0, offw_n} == diag_lo(s_n, ipx));
    acc_n  = (idx_n[0] == len_c[0] - 1'b1) && (s_n == s_last);
    last_n = last_n & acc_n;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      {out_valid, iaddr, waddr, imsb, wmsb, sh, acc_done, busy, done, last_q} <= '0;
      {ip_q, wp_q, ibase_q, wbase_q, s_q, offw_q, offd_q} <= '0;
      for (int k = 0; k < NDIM; k++) begin
        {len_q[k], istr_q[k], wstr_q[k]} <= '0;
        {idx_q[k], isum_q[k], wsum_q[k]} <= '0;
      end
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= RUN;
          busy    <= 1'b1;
          ip_q    <= ip_c;
          wp_q    <= wp_c;
          ibase_q <= ibase_c;
          wbase_q <= wbase_c;
          for (int k = 0; k < NDIM; k++) begin
            len_q[k]  <= len_c[k];
            istr_q[k] <= istr_c[k];
            wstr_q[k] <= wstr_c[k];
          end
        end
        RUN: if (out_ready && last_q) begin
          state <= FIN;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
      // Load the first address on start, or step to the next one on a non-final accept.
      if ((state == IDLE && start) || (state == RUN && out_ready && !last_q)) begin
        out_valid <= 1'b1;
        iaddr     <= iaddr_n;
        waddr     <= waddr_n;
        imsb      <= (offd_n == '0);
        wmsb      <= (offw_n == '0);
        sh        <= sh_n;
        acc_done  <= acc_n;
        last_q    <= last_n;
        s_q       <= s_n;
        offw_q    <= offw_n;
        offd_q    <= offd_n;
        for (int k = 0; k < NDIM; k++) begin
          idx_q[k]  <= idx_n[k];
          isum_q[k] <= isum_n[k];
          wsum_q[k] <= wsum_n[k];
        end
      end else if (state == RUN && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_nd_zigzag_agu.sv
// Scoreboard bench for nd_zigzag_agu: a loop-nest reference model queues expected addresses per job.
module tb_nd_zigzag_agu;
  localparam int NDIM = 4, BPREC = 6, BDBANKA = 15, BWBANKA = 9, BWLENGTH = 8;

  logic clk = 1'b0;
  logic clr, start, out_ready;
  logic [BPREC-1:0] iprecision, wprecision;
  logic [NDIM*BWLENGTH-1:0] length;
  logic [NDIM*BDBANKA-1:0] istride;
  logic [NDIM*BWBANKA-1:0] wstride;
  logic [BDBANKA-1:0] ibaseaddr, iaddr;
  logic [BWBANKA-1:0] wbaseaddr, waddr;
  logic out_valid, imsb, wmsb, sh, acc_done, busy, done;

  always #5 clk = ~clk;

  nd_zigzag_agu #(.NDIM(NDIM), .BPREC(BPREC), .BDBANKA(BDBANKA), .BWBANKA(BWBANKA),
                  .BWLENGTH(BWLENGTH)) dut (
    .clk(clk), .clr(clr), .start(start), .out_ready(out_ready),
    .iprecision(iprecision), .wprecision(wprecision), .length(length),
    .istride(istride), .wstride(wstride), .ibaseaddr(ibaseaddr), .wbaseaddr(wbaseaddr),
    .out_valid(out_valid), .iaddr(iaddr), .waddr(waddr), .imsb(imsb), .wmsb(wmsb),
    .sh(sh), .acc_done(acc_done), .busy(busy), .done(done));

  typedef struct packed {
    logic [BDBANKA-1:0] ia;
    logic [BWBANKA-1:0] wa;
    logic imsb, wmsb, sh, acc;
  } exp_t;

  exp_t sb[$];
  int checks = 0, failures = 0;
  int cfg_len[NDIM], cfg_is[NDIM], cfg_ws[NDIM];
  int cfg_ip, cfg_wp, cfg_ib, cfg_wb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input int l0, input int l1, input int l2, input int l3,
                         input int ip, input int wp, input int ib, input int wb,
                         input int s_i, input int s_w);
    cfg_len[0] = l0; cfg_len[1] = l1; cfg_len[2] = l2; cfg_len[3] = l3;
    for (int k = 0; k < NDIM; k++) begin
      cfg_is[k] = s_i * (k + 1) + k * 7;
      cfg_ws[k] = s_w * (k + 2) + k * 3;
    end
    cfg_ip = ip; cfg_wp = wp; cfg_ib = ib; cfg_wb = wb;
  endtask

  task automatic apply_cfg();
    iprecision = BPREC'(cfg_ip);
    wprecision = BPREC'(cfg_wp);
    ibaseaddr  = BDBANKA'(cfg_ib);
    wbaseaddr  = BWBANKA'(cfg_wb);
    for (int k = 0; k < NDIM; k++) begin
      length[k*BWLENGTH +: BWLENGTH] = BWLENGTH'(cfg_len[k]);
      istride[k*BDBANKA +: BDBANKA]  = BDBANKA'(cfg_is[k]);
      wstride[k*BWBANKA +: BWBANKA]  = BWBANKA'(cfg_ws[k]);
    end
  endtask

  // Reference order: level 3..1 outermost, then zig-zag diagonals, then level 0.
  task automatic build_model();
    int l[NDIM];
    int ipn, wpn, pair, a_i, a_w;
    bit first;
    exp_t e;
    for (int k = 0; k < NDIM; k++) l[k] = (cfg_len[k] == 0) ? 1 : cfg_len[k];
    ipn = (cfg_ip == 0) ? 1 : cfg_ip;
    wpn = (cfg_wp == 0) ? 1 : cfg_wp;
    for (int i3 = 0; i3 < l[3]; i3++)
      for (int i2 = 0; i2 < l[2]; i2++)
        for (int i1 = 0; i1 < l[1]; i1++) begin
          pair = 0;
          for (int s = 0; s <= ipn + wpn - 2; s++) begin
            first = 1'b1;
            for (int ow = 0; ow < wpn; ow++) begin
              int od;
              od = s - ow;
              if (od < 0 || od >= ipn) continue;
              for (int i0 = 0; i0 < l[0]; i0++) begin
                a_i = cfg_ib + i0*cfg_is[0] + i1*cfg_is[1] + i2*cfg_is[2] + i3*cfg_is[3] + od;
                a_w = cfg_wb + i0*cfg_ws[0] + i1*cfg_ws[1] + i2*cfg_ws[2] + i3*cfg_ws[3] + ow;
                e.ia   = BDBANKA'(a_i);
                e.wa   = BWBANKA'(a_w);
                e.imsb = (od == 0);
                e.wmsb = (ow == 0);
                e.sh   = first && (i0 == 0);
                e.acc  = (pair == ipn*wpn - 1) && (i0 == l[0] - 1);
                sb.push_back(e);
              end
              first = 1'b0;
              pair++;
            end
          end
        end
  endtask

  task automatic run_job(input int ready_pct, input int start_at, input int clr_after,
                         input int exp_count);
    int n_acc;
    bit fin, stalled;
    logic [BDBANKA-1:0] h_ia;
    logic [BWBANKA-1:0] h_wa;
    exp_t e;
    n_acc = 0; fin = 1'b0; stalled = 1'b0; h_ia = '0; h_wa = '0;
    apply_cfg();
    build_model();
    start = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      start = (cyc == start_at);
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_iaddr", iaddr, h_ia);
        check("stall_waddr", waddr, h_wa);
      end
      if (done) begin
        check("done_no_valid", out_valid, 0);
        check("done_busy", busy, 1);
        fin = 1'b1;
      end else begin
        out_ready = ($urandom_range(99) < ready_pct);
        stalled = out_valid && !out_ready;
        h_ia = iaddr;
        h_wa = waddr;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) check("extra_addr", 1, 0);
          else begin
            e = sb.pop_front();
            check("iaddr", iaddr, e.ia);
            check("waddr", waddr, e.wa);
            check("imsb", imsb, e.imsb);
            check("wmsb", wmsb, e.wmsb);
            check("sh", sh, e.sh);
            check("acc_done", acc_done, e.acc);
          end
          n_acc++;
          if (n_acc == clr_after) begin
            @(negedge clk);
            clr = 1'b1; out_ready = 1'b0; start = 1'b0;
            @(negedge clk);
            clr = 1'b0;
            check("clr_valid", out_valid, 0);
            check("clr_busy", busy, 0);
            check("clr_done", done, 0);
            repeat (3) begin
              @(negedge clk);
              check("clr_no_done", done, 0);
            end
            sb.delete();
            return;
          end
        end
      end
      if (!fin) @(negedge clk);
    end
    start = 1'b0;
    if (!fin) check("done_timeout", 0, 1);
    check("addr_count", n_acc, exp_count);
    check("sb_empty", sb.size(), 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; out_ready = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_cfg();
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_iaddr", iaddr, 0);
    check("rst_waddr", waddr, 0);
    clr = 1'b0;
    @(negedge clk);

    set_cfg(0, 0, 0, 0, 0, 0, 5, 3, 9, 4);
    run_job(100, -1, -1, 1);

    set_cfg(1, 1, 1, 1, 2, 3, 0, 0, 0, 0);
    for (int k = 0; k < NDIM; k++) begin cfg_is[k] = 0; cfg_ws[k] = 0; end
    run_job(100, -1, -1, 6);

    set_cfg(4, 1, 1, 1, 1, 1, 'h7FFE, 'h1F0, 0, 0);
    cfg_is[0] = 2; cfg_ws[0] = 5;
    run_job(100, -1, -1, 4);

    set_cfg(3, 2, 2, 1, 2, 2, 'h7F00, 'h1FA, 'h1100, 'h31);
    run_job(50, -1, -1, 48);

    run_job(100, -1, 7, 48);
    run_job(70, -1, -1, 48);

    set_cfg(2, 3, 1, 2, 3, 2, 'h123, 'h45, 'h20, 'h11);
    run_job(100, 5, -1, 72);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
